// File: rtl/sar_result_avg.sv
// Window averager for sar_adc conversion words: sums 2^LOG2_N samples and hands the
// rounded/truncated mean to the system side over valid/ready, flagging lost results.
module sar_result_avg #(
  parameter int RES    = 8,
  parameter int LOG2_N = 2,
  parameter int ROUND  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [RES-1:0]    i_data,
  input  logic              i_data_vld,
  output logic [RES-1:0]    o_avg,
  output logic              o_avg_vld,
  input  logic              i_avg_rdy,
  output logic [LOG2_N:0]   o_cnt,
  output logic              o_ovr,
  input  logic              i_ovr_clr
);

  localparam int ACC_W = RES + LOG2_N;
  localparam int N     = 1 << LOG2_N;
  localparam logic [LOG2_N:0] LAST    = (LOG2_N+1)'(N - 1);
  localparam logic [LOG2_N:0] CNT_ONE = (LOG2_N+1)'(1);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next, acc_sum;
  logic [LOG2_N:0]  cnt_reg, cnt_next;
  logic [RES-1:0]   avg_reg;
  logic             ovr_reg;
  logic             accept, win_done, handshake, load, ovr_set;
  logic [ACC_W:0]   rnd_sum;
  logic [RES:0]     shifted;
  logic [RES-1:0]   mean;

  assign accept    = i_en && i_data_vld;
  assign win_done  = accept && (cnt_reg == LAST);
  assign handshake = (state_reg == ST_FULL) && i_avg_rdy;
  assign acc_sum   = acc_reg + ACC_W'(i_data);

  // Mean is computed from the sum including the sample accepted on this edge.
  generate
    if (LOG2_N > 0 && ROUND != 0) begin : g_round
      assign rnd_sum = {1'b0, acc_sum} + (ACC_W+1)'(1 << (LOG2_N - 1));
    end else begin : g_trunc
      assign rnd_sum = {1'b0, acc_sum};
    end
  endgenerate

  assign shifted = (RES+1)'(rnd_sum >> LOG2_N);
  assign mean    = shifted[RES] ? {RES{1'b1}} : shifted[RES-1:0];

  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (!i_en || win_done) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (accept) begin
      acc_next = acc_sum;
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    ovr_set    = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (win_done) begin
          load       = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (handshake && win_done) begin
          load = 1'b1;
        end else if (handshake) begin
          state_next = ST_EMPTY;
        end else if (win_done) begin
          // Consumer stalled: the older mean is kept, the new one is dropped.
          ovr_set = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_EMPTY;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      avg_reg   <= '0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        avg_reg <= mean;
      end
      ovr_reg   <= ovr_set | (ovr_reg & ~i_ovr_clr);
    end
  end

  assign o_avg     = avg_reg;
  assign o_avg_vld = (state_reg == ST_FULL);
  assign o_cnt     = cnt_reg;
  assign o_ovr     = ovr_reg;

endmodule

// File: tb/tb_sar_result_avg.sv
// Directed bench for sar_result_avg: rounding, truncating and pass-through instances
// share one stimulus stream; window results come from a hand-computed vector table.
module tb_sar_result_avg;

  logic       i_clk = 1'b0;
  logic       i_rst, i_en, i_data_vld, i_avg_rdy, i_ovr_clr;
  logic [7:0] i_data;

  logic [7:0] avg_r, avg_t, avg_p;
  logic       vld_r, vld_t, vld_p;
  logic [2:0] cnt_r, cnt_t;
  logic [0:0] cnt_p;
  logic       ovr_r, ovr_t, ovr_p;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  logic [7:0] last_xfer = '0;

  always #5 i_clk = ~i_clk;

  sar_result_avg #(.RES(8), .LOG2_N(2), .ROUND(1)) dut_r (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data), .i_data_vld(i_data_vld),
    .o_avg(avg_r), .o_avg_vld(vld_r), .i_avg_rdy(i_avg_rdy), .o_cnt(cnt_r),
    .o_ovr(ovr_r), .i_ovr_clr(i_ovr_clr));

  sar_result_avg #(.RES(8), .LOG2_N(2), .ROUND(0)) dut_t (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data), .i_data_vld(i_data_vld),
    .o_avg(avg_t), .o_avg_vld(vld_t), .i_avg_rdy(i_avg_rdy), .o_cnt(cnt_t),
    .o_ovr(ovr_t), .i_ovr_clr(i_ovr_clr));

  sar_result_avg #(.RES(8), .LOG2_N(0), .ROUND(1)) dut_p (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data(i_data), .i_data_vld(i_data_vld),
    .o_avg(avg_p), .o_avg_vld(vld_p), .i_avg_rdy(i_avg_rdy), .o_cnt(cnt_p),
    .o_ovr(ovr_p), .i_ovr_clr(i_ovr_clr));

  // Records every transfer accepted by the rounding instance.
  always @(posedge i_clk) begin
    if (!i_rst && vld_r && i_avg_rdy) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= avg_r;
    end
  end

  typedef struct {
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] exp_r, exp_t, exp_p;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic send(input logic [7:0] d);
    i_data     = d;
    i_data_vld = 1'b1;
    @(posedge i_clk);
    #1;
    i_data_vld = 1'b0;
  endtask

  task automatic idle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send4(input logic [7:0] d);
    for (int k = 0; k < 4; k++) send(d);
  endtask

  initial begin
    logic [7:0] s [4];
    int x0;

    vecs[0] = '{10, 11, 12, 13, 12, 11, 13};
    vecs[1] = '{255, 255, 255, 255, 255, 255, 255};
    vecs[2] = '{0, 0, 0, 1, 0, 0, 1};
    vecs[3] = '{1, 1, 1, 3, 2, 1, 3};
    vecs[4] = '{2, 2, 2, 3, 2, 2, 3};
    vecs[5] = '{100, 200, 50, 7, 89, 89, 7};
    vecs[6] = '{0, 0, 1, 1, 1, 0, 1};

    i_rst = 1'b1; i_en = 1'b0; i_data = '0; i_data_vld = 1'b0;
    i_avg_rdy = 1'b1; i_ovr_clr = 1'b0;
    idle(); idle();
    check("reset_avg", avg_r, 0);
    check("reset_vld", vld_r, 0);
    check("reset_cnt", cnt_r, 0);
    check("reset_ovr", ovr_r, 0);
    i_rst = 1'b0;
    i_en  = 1'b1;
    idle();

    // Table: one window per record, consumer always ready.
    for (int v = 0; v < 7; v++) begin
      s = '{vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3};
      for (int j = 0; j < 4; j++) begin
        send(s[j]);
        check($sformatf("v%0d_cnt%0d", v, j), cnt_r, (j + 1) % 4);
      end
      check($sformatf("v%0d_vld", v), vld_r, 1);
      check($sformatf("v%0d_avg_round", v), avg_r, vecs[v].exp_r);
      check($sformatf("v%0d_avg_trunc", v), avg_t, vecs[v].exp_t);
      check($sformatf("v%0d_avg_pass", v), avg_p, vecs[v].exp_p);
      idle();
      check($sformatf("v%0d_drained", v), vld_r, 0);
      check($sformatf("v%0d_xfer", v), last_xfer, vecs[v].exp_r);
    end

    // Stalled consumer across two windows; overrun set beats a same-edge clear.
    i_avg_rdy = 1'b0;
    send4(1);
    send(9); send(9); send(9);
    i_ovr_clr = 1'b1;
    send(9);
    i_ovr_clr = 1'b0;
    check("ovr_avg_kept", avg_r, 1);
    check("ovr_vld_held", vld_r, 1);
    check("ovr_set_wins", ovr_r, 1);
    x0 = xfer_cnt;
    i_avg_rdy = 1'b1;
    idle();
    check("ovr_one_xfer", xfer_cnt - x0, 1);
    check("ovr_xfer_val", last_xfer, 1);
    check("ovr_vld_drop", vld_r, 0);
    check("ovr_sticky", ovr_r, 1);
    i_ovr_clr = 1'b1;
    idle();
    i_ovr_clr = 1'b0;
    check("ovr_cleared", ovr_r, 0);

    // Window completes on the same edge the consumer takes the older mean.
    i_avg_rdy = 1'b0;
    send4(3);
    check("bb_first", avg_r, 3);
    send(5); send(5); send(5);
    x0 = xfer_cnt;
    i_avg_rdy = 1'b1;
    send(5);
    check("bb_xfer_cnt", xfer_cnt - x0, 1);
    check("bb_xfer_val", last_xfer, 3);
    check("bb_avg_new", avg_r, 5);
    check("bb_vld_stays", vld_r, 1);
    check("bb_no_ovr", ovr_r, 0);
    idle();
    check("bb_drained", vld_r, 0);

    // Dropping enable discards a partial window.
    send(7); send(7);
    check("en_partial_cnt", cnt_r, 2);
    i_en = 1'b0;
    idle();
    check("en_clear_cnt", cnt_r, 0);
    i_en = 1'b1;
    send4(4);
    check("en_avg", avg_r, 4);
    idle();

    // Reset while FULL with an overrun and a partial window pending.
    i_avg_rdy = 1'b0;
    send4(6);
    send4(6);
    send(6); send(6);
    check("prerst_ovr", ovr_r, 1);
    check("prerst_cnt", cnt_r, 2);
    i_rst = 1'b1;
    idle();
    i_rst = 1'b0;
    check("rst_avg", avg_r, 0);
    check("rst_vld", vld_r, 0);
    check("rst_cnt", cnt_r, 0);
    check("rst_ovr", ovr_r, 0);
    i_avg_rdy = 1'b1;
    send4(8);
    check("postrst_avg", avg_r, 8);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_result_avg.md
Name: sar_result_avg

Overview:
Downstream post-processing stage for sar_adc. It consumes each completed conversion word from the digital back end and accumulates a window of 2^LOG2_N conversions. It then presents the window mean to the system side over a valid/ready handshake. An overrun flag covers the case where the consumer stalls.

Parameters:
RES, 8, conversion word width in bits; must match the DBE result width.
LOG2_N, 2, log2 of the window length; N = 2^LOG2_N samples, legal range 0..6.
ROUND, 1, 1 = round half up before the shift, 0 = truncate.

Ports:
i_clk  in  1  system clock, shared with the DBE.
i_rst  in  1  synchronous reset, active-high.
i_en  in  1  averaging enable; low clears the window in progress.
i_data  in  RES  conversion result from the DBE.
i_data_vld  in  1  single-cycle strobe: i_data holds a finished conversion.
o_avg  out  RES  window mean.
o_avg_vld  out  1  o_avg is valid and held until accepted.
i_avg_rdy  in  1  consumer ready; a transfer occurs when o_avg_vld && i_avg_rdy.
o_cnt  out  LOG2_N+1  number of samples in the current window.
o_ovr  out  1  sticky overrun flag.
i_ovr_clr  in  1  clears o_ovr.

Behaviour:
- Reset (i_rst=1 at a clock edge): accumulator=0, o_cnt=0, o_avg=0, o_avg_vld=0, o_ovr=0. Reset overrides every other input and aborts any window in progress.
- Accumulator width is RES+LOG2_N bits, so it cannot overflow. Samples are unsigned.
- Sample accept: i_en && i_data_vld at an edge. The accumulator adds i_data and o_cnt increments. Samples arriving with i_en=0 are ignored.
- i_en=0: accumulator and o_cnt clear on the next edge. The output register and o_ovr are untouched.
- Window complete: the accept edge of sample N.
  - Mean = (acc_final + (ROUND ? 2^(LOG2_N-1) : 0)) >> LOG2_N, saturated to 2^RES-1.
  - Rounding applies only when LOG2_N>0. With LOG2_N=0 the input passes through with 1-cycle latency.
  - Accumulator and o_cnt return to 0 on the same edge. Back-to-back windows lose no samples.
- Latency: o_avg_vld rises in the cycle after the edge that accepted sample N.
- Output register FSM:
  - EMPTY: o_avg_vld=0. On window complete, load o_avg and go to FULL.
  - FULL: o_avg_vld=1 and o_avg is stable.
    - Handshake only: go to EMPTY.
    - Handshake and window complete on the same edge: load the new mean and stay FULL (no bubble, no overrun).
    - Window complete without handshake: discard the new mean, keep the old o_avg, set o_ovr.
- o_ovr: set by the overrun above and held until i_ovr_clr=1 or reset. If a set and i_ovr_clr occur on the same edge, set wins.
- i_avg_rdy is ignored while o_avg_vld=0. o_avg_vld never drops without a handshake, except on reset.

Test Plan:
1. Reset, i_en=1, RES=8, LOG2_N=2, ROUND=1, feed 10, 11, 12, 13 with i_avg_rdy=1 -> one cycle after the 4th strobe: o_avg_vld=1, o_avg=12 (46+2=48, 48>>2=12); o_cnt sequence 1, 2, 3, 0.
2. Same run with ROUND=0 -> o_avg=11.
3. Feed 255 ×4 -> o_avg=255, no wrap.
4. Hold i_avg_rdy=0 across two full windows (1,1,1,1 then 9,9,9,9) -> o_avg stays 1, o_ovr=1. Raise rdy -> one transfer of 1. Pulse i_ovr_clr -> o_ovr=0.
5. Complete the window with mean 5 while FULL with 3, raising i_avg_rdy on that same edge -> 3 transfers, o_avg=5 next cycle, o_avg_vld stays 1, o_ovr=0.
6. Send 2 samples, drop i_en for 1 cycle, then feed 4,4,4,4 -> o_avg=4 (partial window discarded). Separately, assert i_rst mid-window and mid-FULL -> all outputs return to 0 on the next edge.
